// File: rtl/mig_user_pkg.sv
// Shared app-interface widths, MIG command codes and burst FSM states
// for the DDR3 user-side masters on the Acorn board.
package mig_user_pkg;
  localparam int APP_ADDR_W = 29;
  localparam int APP_DATA_W = 128;
  localparam int APP_MASK_W = APP_DATA_W / 8;

  localparam logic [2:0] CMD_WRITE = 3'b000;
  localparam logic [2:0] CMD_READ  = 3'b001;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN
  } state_t;
endpackage

// File: rtl/mig_burst_master.sv
// Burst initiator on the MIG 7-series native app interface: writes from a
// valid/ready stream, reads returned as a valid-only stream.
module mig_burst_master
  import mig_user_pkg::*;
#(
  parameter int ADDR_W    = APP_ADDR_W,
  parameter int DATA_W    = APP_DATA_W,
  parameter int LEN_W     = 8,
  parameter int ADDR_STEP = 8
) (
  input  logic                clk,
  input  logic                resetn,
  input  logic                init_calib_complete,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_write,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [LEN_W-1:0]    req_len,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  output logic                done,
  output logic [ADDR_W-1:0]   app_addr,
  output logic [2:0]          app_cmd,
  output logic                app_en,
  input  logic                app_rdy,
  output logic [DATA_W-1:0]   app_wdf_data,
  output logic [DATA_W/8-1:0] app_wdf_mask,
  output logic                app_wdf_wren,
  output logic                app_wdf_end,
  input  logic                app_wdf_rdy,
  input  logic [DATA_W-1:0]   app_rd_data,
  input  logic                app_rd_data_valid,
  input  logic                app_rd_data_end,
  output logic                app_ref_req,
  output logic                app_zq_req
);
  state_t             state_reg, state_next;
  logic [LEN_W-1:0]   len_reg, len_next;
  logic [LEN_W-1:0]   beat_cnt_reg, beat_cnt_next;
  logic [LEN_W-1:0]   rtn_cnt_reg, rtn_cnt_next;
  logic [LEN_W:0]     data_cnt_reg, data_cnt_next;
  logic               cmd_done_reg, cmd_done_next;
  logic               wdf_done_reg, wdf_done_next;
  logic               skid_full_reg, skid_full_next;
  logic [DATA_W-1:0]  skid_data_reg, skid_data_next;
  logic [ADDR_W-1:0]  app_addr_next;
  logic [2:0]         app_cmd_next;
  logic               app_en_next, wren_next, req_ready_next, wr_ready_next;
  logic               rd_valid_next, done_next;
  logic [DATA_W-1:0]  wdf_data_next, rd_data_next;
  logic               unused_rd_end;

  logic cmd_hs, wdf_hs, cmd_ok, wdf_ok, beat_end, wr_take, rtn_last;

  assign cmd_hs   = app_en && app_rdy;
  assign wdf_hs   = app_wdf_wren && app_wdf_rdy;
  assign cmd_ok   = cmd_done_reg || cmd_hs;
  assign wdf_ok   = wdf_done_reg || wdf_hs;
  assign beat_end = cmd_ok && wdf_ok;
  assign wr_take  = wr_ready && wr_valid;
  assign rtn_last = app_rd_data_valid && (rtn_cnt_reg == len_reg);

  assign app_wdf_end   = app_wdf_wren;
  assign app_wdf_mask  = '0;
  assign app_ref_req   = 1'b0;
  assign app_zq_req    = 1'b0;
  assign unused_rd_end = app_rd_data_end;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_reg     <= ST_IDLE;
      len_reg       <= '0;
      beat_cnt_reg  <= '0;
      rtn_cnt_reg   <= '0;
      data_cnt_reg  <= '0;
      cmd_done_reg  <= 1'b0;
      wdf_done_reg  <= 1'b0;
      skid_full_reg <= 1'b0;
      skid_data_reg <= '0;
      app_addr      <= '0;
      app_cmd       <= CMD_WRITE;
      app_en        <= 1'b0;
      app_wdf_wren  <= 1'b0;
      app_wdf_data  <= '0;
      req_ready     <= 1'b0;
      wr_ready      <= 1'b0;
      rd_valid      <= 1'b0;
      rd_data       <= '0;
      done          <= 1'b0;
    end else begin
      state_reg     <= state_next;
      len_reg       <= len_next;
      beat_cnt_reg  <= beat_cnt_next;
      rtn_cnt_reg   <= rtn_cnt_next;
      data_cnt_reg  <= data_cnt_next;
      cmd_done_reg  <= cmd_done_next;
      wdf_done_reg  <= wdf_done_next;
      skid_full_reg <= skid_full_next;
      skid_data_reg <= skid_data_next;
      app_addr      <= app_addr_next;
      app_cmd       <= app_cmd_next;
      app_en        <= app_en_next;
      app_wdf_wren  <= wren_next;
      app_wdf_data  <= wdf_data_next;
      req_ready     <= req_ready_next;
      wr_ready      <= wr_ready_next;
      rd_valid      <= rd_valid_next;
      rd_data       <= rd_data_next;
      done          <= done_next;
    end
  end

  always_comb begin
    state_next     = state_reg;
    len_next       = len_reg;
    beat_cnt_next  = beat_cnt_reg;
    rtn_cnt_next   = rtn_cnt_reg;
    data_cnt_next  = data_cnt_reg;
    cmd_done_next  = cmd_done_reg;
    wdf_done_next  = wdf_done_reg;
    skid_full_next = skid_full_reg;
    skid_data_next = skid_data_reg;
    app_addr_next  = app_addr;
    app_cmd_next   = app_cmd;
    app_en_next    = app_en;
    wren_next      = app_wdf_wren;
    wdf_data_next  = app_wdf_data;
    rd_valid_next  = 1'b0;
    rd_data_next   = rd_data;
    done_next      = 1'b0;

    // Returned read beats are only meaningful while a read burst is open.
    if ((state_reg == ST_READ || state_reg == ST_DRAIN) && app_rd_data_valid) begin
      rd_valid_next = 1'b1;
      rd_data_next  = app_rd_data;
      rtn_cnt_next  = rtn_cnt_reg + 1'b1;
    end

    case (state_reg)
      ST_IDLE: begin
        if (req_valid && req_ready) begin
          app_addr_next  = req_addr;
          len_next       = req_len;
          beat_cnt_next  = '0;
          rtn_cnt_next   = '0;
          data_cnt_next  = '0;
          cmd_done_next  = 1'b0;
          wdf_done_next  = 1'b0;
          skid_full_next = 1'b0;
          wren_next      = 1'b0;
          app_en_next    = 1'b1;
          app_cmd_next   = req_write ? CMD_WRITE : CMD_READ;
          state_next     = req_write ? ST_WRITE : ST_READ;
        end
      end
      ST_WRITE: begin
        if (wr_take) data_cnt_next = data_cnt_reg + 1'b1;
        if (beat_end) begin
          cmd_done_next = 1'b0;
          wdf_done_next = 1'b0;
          app_addr_next = app_addr + ADDR_W'(ADDR_STEP);
          beat_cnt_next = beat_cnt_reg + 1'b1;
          app_en_next   = 1'b0;
          wren_next     = 1'b0;
          if (beat_cnt_reg == len_reg) begin
            done_next  = 1'b1;
            state_next = ST_IDLE;
          end else begin
            app_en_next = 1'b1;
            // The spare slot feeds the next beat so a stream word can land every cycle.
            if (skid_full_reg) begin
              wdf_data_next  = skid_data_reg;
              wren_next      = 1'b1;
              skid_full_next = wr_take;
              if (wr_take) skid_data_next = wr_data;
            end else if (wr_take) begin
              wdf_data_next = wr_data;
              wren_next     = 1'b1;
            end
          end
        end else begin
          cmd_done_next = cmd_ok;
          wdf_done_next = wdf_ok;
          app_en_next   = app_en && !app_rdy;
          wren_next     = app_wdf_wren && !app_wdf_rdy;
          if (wr_take) begin
            if (!wdf_ok && !app_wdf_wren) begin
              wdf_data_next = wr_data;
              wren_next     = 1'b1;
            end else begin
              skid_data_next = wr_data;
              skid_full_next = 1'b1;
            end
          end
        end
      end
      ST_READ: begin
        if (cmd_hs) begin
          app_addr_next = app_addr + ADDR_W'(ADDR_STEP);
          beat_cnt_next = beat_cnt_reg + 1'b1;
          if (beat_cnt_reg == len_reg) begin
            app_en_next = 1'b0;
            done_next   = rtn_last;
            state_next  = rtn_last ? ST_IDLE : ST_DRAIN;
          end
        end
      end
      ST_DRAIN: begin
        if (rtn_last) begin
          done_next  = 1'b1;
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase

    req_ready_next = (state_next == ST_IDLE) && init_calib_complete;
    wr_ready_next  = (state_next == ST_WRITE) && !skid_full_next
                     && (data_cnt_next <= {1'b0, len_next});
  end
endmodule

// File: tb/tb_mig_burst_master.sv
// Directed bench for mig_burst_master: bench drives the MIG app side by hand
// and a negedge monitor logs every handshake for later comparison.
module tb_mig_burst_master;
  import mig_user_pkg::*;
  localparam int AW = 29;
  localparam int DW = 128;
  localparam int LW = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          resetn, init_calib_complete;
  logic          req_valid, req_ready, req_write;
  logic [AW-1:0] req_addr;
  logic [LW-1:0] req_len;
  logic [DW-1:0] wr_data, rd_data, app_wdf_data, app_rd_data;
  logic          wr_valid, wr_ready, rd_valid, done;
  logic [AW-1:0] app_addr;
  logic [2:0]    app_cmd;
  logic          app_en, app_rdy, app_wdf_wren, app_wdf_end, app_wdf_rdy;
  logic [DW/8-1:0] app_wdf_mask;
  logic          app_rd_data_valid, app_rd_data_end, app_ref_req, app_zq_req;

  mig_burst_master dut (
    .clk(clk), .resetn(resetn), .init_calib_complete(init_calib_complete),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_len(req_len),
    .wr_data(wr_data), .wr_valid(wr_valid), .wr_ready(wr_ready),
    .rd_data(rd_data), .rd_valid(rd_valid), .done(done),
    .app_addr(app_addr), .app_cmd(app_cmd), .app_en(app_en), .app_rdy(app_rdy),
    .app_wdf_data(app_wdf_data), .app_wdf_mask(app_wdf_mask),
    .app_wdf_wren(app_wdf_wren), .app_wdf_end(app_wdf_end), .app_wdf_rdy(app_wdf_rdy),
    .app_rd_data(app_rd_data), .app_rd_data_valid(app_rd_data_valid),
    .app_rd_data_end(app_rd_data_end), .app_ref_req(app_ref_req), .app_zq_req(app_zq_req)
  );

  int errors = 0;
  int checks = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  logic [AW-1:0] cmd_addr_q[$];
  logic [2:0]    cmd_code_q[$];
  int            cmd_cyc_q[$];
  logic [DW-1:0] wdf_q[$];
  int            wdf_cyc_q[$];
  logic [DW-1:0] rd_q[$];
  int            done_cyc_q[$];
  int            wdf_bad = 0;

  always @(negedge clk) begin
    if (app_en && app_rdy) begin
      cmd_addr_q.push_back(app_addr);
      cmd_code_q.push_back(app_cmd);
      cmd_cyc_q.push_back(cyc);
    end
    if (app_wdf_wren && app_wdf_rdy) begin
      wdf_q.push_back(app_wdf_data);
      wdf_cyc_q.push_back(cyc);
      if (app_wdf_end !== 1'b1 || app_wdf_mask !== '0) wdf_bad++;
    end
    if (rd_valid) rd_q.push_back(rd_data);
    if (done) done_cyc_q.push_back(cyc);
  end

  function automatic logic [DW-1:0] wdata(input int k);
    return {32'hC0DE0000 + 32'(k), 32'h0, ~32'(k), 32'h5A5A0000 + 32'(k)};
  endfunction

  // Write-data source: presents word wr_idx until it is accepted.
  int   wr_idx = 0;
  int   wr_total = 0;
  logic wr_hs;
  initial begin
    wr_valid = 1'b0;
    wr_data  = '0;
    forever begin
      @(negedge clk);
      wr_hs = wr_valid && wr_ready;
      @(posedge clk);
      #1;
      if (wr_hs) wr_idx++;
      wr_valid = (wr_idx < wr_total);
      wr_data  = wdata(wr_idx);
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send_req(input logic wr, input logic [AW-1:0] a, input logic [LW-1:0] l);
    bit ok;
    ok = 1'b0;
    @(posedge clk);
    #1;
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = a;
    req_len   = l;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (req_ready) begin
        ok = 1'b1;
        break;
      end
    end
    chk("req_accept", ok, 1);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    @(negedge clk);
    chk("first_en", app_en, 1);
    chk("first_cmd", app_cmd, wr ? CMD_WRITE : CMD_READ);
    chk("first_addr", app_addr, a);
  endtask

  task automatic wait_done(input int base, input int limit);
    int n;
    n = 0;
    @(negedge clk);
    #1;
    while (done_cyc_q.size() <= base && n < limit) begin
      @(negedge clk);
      #1;
      n++;
    end
    chk("done_seen", done_cyc_q.size() > base, 1);
  endtask

  initial begin
    int cb, wb, rb, db, seen, bad, last_hs;
    logic [AW-1:0] ea;
    resetn = 1'b0; init_calib_complete = 1'b0;
    req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_len = '0;
    app_rdy = 1'b1; app_wdf_rdy = 1'b1;
    app_rd_data = '0; app_rd_data_valid = 1'b0; app_rd_data_end = 1'b0;

    // Reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_req_ready", req_ready, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_done", done, 0);
    chk("rst_app_en", app_en, 0);
    chk("rst_wren", app_wdf_wren, 0);
    chk("rst_wdf_end", app_wdf_end, 0);
    chk("rst_app_cmd", app_cmd, 3'b000);
    chk("rst_app_addr", app_addr, 0);
    chk("rst_mask", app_wdf_mask, 0);
    chk("rst_data_out", rd_data | app_wdf_data, 0);
    chk("rst_ref_zq", {app_ref_req, app_zq_req}, 0);
    @(posedge clk);
    #1;
    resetn = 1'b1;

    // Calibration gating: a pending request is not taken
    req_valid = 1'b1; req_write = 1'b1; req_addr = 29'h100; req_len = 8'd3;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (req_ready || app_en) seen++;
    end
    chk("calib_gate", seen, 0);
    chk("calib_no_cmd", cmd_addr_q.size(), 0);

    // Write len=3 at 0x100, everything ready
    wr_total = 4;
    @(posedge clk);
    #1;
    init_calib_complete = 1'b1;
    cb = cmd_addr_q.size(); wb = wdf_q.size(); db = done_cyc_q.size();
    send_req(1'b1, 29'h100, 8'd3);
    wait_done(db, 50);
    repeat (3) @(negedge clk);
    #1;
    chk("wr4_cmd_count", cmd_addr_q.size() - cb, 4);
    chk("wr4_wdf_count", wdf_q.size() - wb, 4);
    chk("wr4_done_count", done_cyc_q.size() - db, 1);
    if (cmd_addr_q.size() >= cb + 4 && wdf_q.size() >= wb + 4 && done_cyc_q.size() > db) begin
      bad = 0;
      for (int i = 0; i < 4; i++) begin
        if (cmd_addr_q[cb+i] !== 29'(32'h100 + 8*i)) bad++;
        if (cmd_code_q[cb+i] !== CMD_WRITE) bad++;
        if (wdf_q[wb+i] !== wdata(i)) bad++;
      end
      chk("wr4_beats_bad", bad, 0);
      chk("wr4_addr3", cmd_addr_q[cb+3], 29'h118);
      chk("wr4_data0", wdf_q[wb], wdata(0));
      last_hs = (cmd_cyc_q[cb+3] > wdf_cyc_q[wb+3]) ? cmd_cyc_q[cb+3] : wdf_cyc_q[wb+3];
      chk("wr4_done_timing", done_cyc_q[db], last_hs + 1);
      chk("wr4_back_to_back", cmd_cyc_q[cb+3] - cmd_cyc_q[cb+1], 2);
    end
    chk("wr4_wdf_end_mask", wdf_bad, 0);

    // Read len=0 at 0x40, data returned 10 cycles later
    app_rdy = 1'b1;
    cb = cmd_addr_q.size(); rb = rd_q.size(); db = done_cyc_q.size();
    send_req(1'b0, 29'h40, 8'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done || rd_valid || req_ready) seen++;
    end
    chk("rd1_drain_wait", seen, 0);
    chk("rd1_cmd_count", cmd_addr_q.size() - cb, 1);
    if (cmd_addr_q.size() > cb) chk("rd1_cmd_code", cmd_code_q[cb], CMD_READ);
    @(posedge clk);
    #1;
    app_rd_data_valid = 1'b1;
    app_rd_data = {16{8'hA5}};
    @(posedge clk);
    #1;
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    @(negedge clk);
    chk("rd1_rd_valid", rd_valid, 1);
    chk("rd1_rd_data", rd_data, {16{8'hA5}});
    chk("rd1_done", done, 1);
    @(negedge clk);
    chk("rd1_rd_valid_drop", rd_valid, 0);
    #1;
    chk("rd1_rd_count", rd_q.size() - rb, 1);

    // Write len=0 at 0x200 with app_rdy low for 5 cycles
    wr_total = 5;
    app_rdy = 1'b0;
    cb = cmd_addr_q.size(); wb = wdf_q.size(); db = done_cyc_q.size();
    send_req(1'b1, 29'h200, 8'd0);
    bad = 0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      if (app_en !== 1'b1 || app_addr !== 29'h200 || app_cmd !== CMD_WRITE) bad++;
    end
    chk("stall_cmd_stable", bad, 0);
    chk("stall_data_first", wdf_q.size() - wb, 1);
    @(posedge clk);
    #1;
    app_rdy = 1'b1;
    wait_done(db, 20);
    repeat (3) @(negedge clk);
    #1;
    chk("stall_cmd_count", cmd_addr_q.size() - cb, 1);
    chk("stall_wdf_count", wdf_q.size() - wb, 1);
    if (cmd_addr_q.size() > cb && wdf_q.size() > wb) begin
      chk("stall_addr", cmd_addr_q[cb], 29'h200);
      chk("stall_data", wdf_q[wb], wdata(4));
      chk("stall_order", wdf_cyc_q[wb] < cmd_cyc_q[cb], 1);
    end

    // Read len=255 from 2^29-128: address wraps to 0 after 0x1FFFFFF8
    app_rdy = 1'b1;
    cb = cmd_addr_q.size(); rb = rd_q.size(); db = done_cyc_q.size();
    send_req(1'b0, 29'h1FFFFF80, 8'd255);
    repeat (260) @(negedge clk);
    for (int i = 0; i < 256; i++) begin
      @(posedge clk);
      #1;
      app_rd_data_valid = 1'b1;
      app_rd_data = {32'hBEEF0000, 64'h0, 32'(i)};
    end
    @(posedge clk);
    #1;
    app_rd_data_valid = 1'b0;
    wait_done(db, 20);
    repeat (3) @(negedge clk);
    #1;
    chk("wrap_cmd_count", cmd_addr_q.size() - cb, 256);
    chk("wrap_rd_count", rd_q.size() - rb, 256);
    chk("wrap_done_count", done_cyc_q.size() - db, 1);
    if (cmd_addr_q.size() >= cb + 256 && rd_q.size() >= rb + 256) begin
      bad = 0;
      for (int i = 0; i < 256; i++) begin
        ea = 29'h1FFFFF80 + 29'(8*i);
        if (cmd_addr_q[cb+i] !== ea || cmd_code_q[cb+i] !== CMD_READ) bad++;
        if (rd_q[rb+i] !== {32'hBEEF0000, 64'h0, 32'(i)}) bad++;
      end
      chk("wrap_beats_bad", bad, 0);
      chk("wrap_addr15", cmd_addr_q[cb+15], 29'h1FFFFFF8);
      chk("wrap_addr16", cmd_addr_q[cb+16], 29'h0);
      chk("wrap_addr255", cmd_addr_q[cb+255], 29'h778);
    end

    // Reset mid-read, then stale return data, then a normal write
    app_rdy = 1'b1;
    send_req(1'b0, 29'h300, 8'd3);
    @(negedge clk);
    resetn = 1'b0;
    #1;
    chk("mrst_app_en", app_en, 0);
    chk("mrst_app_addr", app_addr, 0);
    chk("mrst_app_cmd", app_cmd, 3'b000);
    chk("mrst_req_ready", req_ready, 0);
    chk("mrst_flags", {rd_valid, done, app_wdf_wren, wr_ready}, 0);
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    resetn = 1'b1;
    rb = rd_q.size(); db = done_cyc_q.size();
    app_rd_data_valid = 1'b1;
    app_rd_data = 128'hDEAD;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    app_rd_data_valid = 1'b0;
    app_rd_data = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("stale_rd_dropped", rd_q.size() - rb, 0);
    chk("stale_no_done", done_cyc_q.size() - db, 0);

    wr_total = 7;
    cb = cmd_addr_q.size(); wb = wdf_q.size(); db = done_cyc_q.size();
    send_req(1'b1, 29'h400, 8'd1);
    wait_done(db, 50);
    repeat (3) @(negedge clk);
    #1;
    chk("post_cmd_count", cmd_addr_q.size() - cb, 2);
    chk("post_wdf_count", wdf_q.size() - wb, 2);
    if (cmd_addr_q.size() >= cb + 2 && wdf_q.size() >= wb + 2) begin
      chk("post_addr1", cmd_addr_q[cb+1], 29'h408);
      chk("post_data0", wdf_q[wb], wdata(5));
      chk("post_data1", wdf_q[wb+1], wdata(6));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
